// File: rtl/stc_row_sched.sv
// stc_row_sched: feeds one output row at a time into the sparse tensor-core PE
// (C load, A/B issue, settle) and hands the finished D row downstream.
`default_nettype none

module stc_row_sched #(
  parameter int N       = 32,
  parameter int DW_DATA = 8,
  parameter int K       = 32,
  parameter int MUL_LAT = 1,
  localparam int CW     = (K > 1) ? $clog2(K) : 1,
  localparam int RW     = N * DW_DATA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_valid,
  output logic               c_ready,
  input  logic [RW-1:0]      c_row,
  input  logic               c_empty,
  input  logic               nz_valid,
  output logic               nz_ready,
  input  logic [DW_DATA-1:0] nz_value,
  input  logic [CW-1:0]      nz_col,
  input  logic               nz_last,
  output logic               b_rd_en,
  output logic [CW-1:0]      b_rd_addr,
  input  logic [RW-1:0]      b_rd_data,
  output logic [DW_DATA-1:0] pe_A_element,
  output logic [RW-1:0]      pe_B_row,
  output logic [RW-1:0]      pe_C_row,
  output logic               pe_load_en,
  output logic               pe_acc_en,
  input  logic [RW-1:0]      pe_D_row,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [RW-1:0]      d_row,
  output logic               busy,
  output logic               err_oob
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [CW:0] C_K          = (CW + 1)'(K);
  localparam logic [1:0]  C_DRAIN_LAST = 2'(MUL_LAT);

  logic [2:0]         r_state;
  logic [RW-1:0]      r_c_row;
  logic               r_c_empty;
  logic               r_iss_vld;
  logic [DW_DATA-1:0] r_iss_val;
  logic [1:0]         r_drain_cnt;
  logic               r_err_oob;

  logic w_nz_hs;
  logic w_oob;

  // Ready/valid strobes decode state only, so no input reaches them combinationally.
  assign c_ready  = (r_state == S_IDLE);
  assign nz_ready = (r_state == S_ISSUE);
  assign d_valid  = (r_state == S_OUT);
  assign busy     = (r_state != S_IDLE);
  assign err_oob  = r_err_oob;

  assign w_nz_hs   = nz_valid & nz_ready;
  assign w_oob     = ({1'b0, nz_col} >= C_K);
  assign b_rd_en   = w_nz_hs & ~w_oob;
  assign b_rd_addr = w_nz_hs ? nz_col : '0;

  // Outside an issued-product cycle A and B are zero, so the PE psum holds.
  assign pe_A_element = r_iss_vld ? r_iss_val : '0;
  assign pe_B_row     = r_iss_vld ? b_rd_data : '0;
  assign pe_acc_en    = r_iss_vld;
  assign pe_load_en   = (r_state == S_LOAD);
  assign pe_C_row     = pe_load_en ? r_c_row : '0;
  assign d_row        = d_valid ? pe_D_row : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_c_row     <= '0;
      r_c_empty   <= 1'b0;
      r_iss_vld   <= 1'b0;
      r_iss_val   <= '0;
      r_drain_cnt <= '0;
      r_err_oob   <= 1'b0;
    end else begin
      r_iss_vld <= w_nz_hs & ~w_oob;
      r_iss_val <= (w_nz_hs && !w_oob) ? nz_value : '0;
      r_err_oob <= r_err_oob | (w_nz_hs & w_oob);
      case (r_state)
        S_IDLE: begin
          if (c_valid) begin
            r_c_row   <= c_row;
            r_c_empty <= c_empty;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_drain_cnt <= '0;
          r_state     <= r_c_empty ? S_DRAIN : S_ISSUE;
        end
        S_ISSUE: begin
          if (w_nz_hs && nz_last) r_state <= S_DRAIN;
        end
        // The last product needs MUL_LAT+1 cycles to land in the PE psum.
        S_DRAIN: begin
          if (r_drain_cnt == C_DRAIN_LAST) r_state <= S_OUT;
          else r_drain_cnt <= r_drain_cnt + 2'd1;
        end
        S_OUT: begin
          if (d_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stc_row_sched.sv
// tb_stc_row_sched: directed rows against a behavioural PE and B buffer,
// with a queue-based scoreboard checking D rows and their arrival cycle.
`default_nettype none

module tb_stc_row_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int K  = 30;
  localparam int ML = 1;
  localparam int CW = 5;
  localparam int RW = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_valid = 1'b0, c_empty = 1'b0;
  logic [RW-1:0] c_row = '0;
  logic          nz_valid = 1'b0, nz_last = 1'b0;
  logic [DW-1:0] nz_value = '0;
  logic [CW-1:0] nz_col = '0;
  logic          d_ready = 1'b1;
  logic [RW-1:0] b_rd_data = '0;
  logic [RW-1:0] psum = '0, prod = '0;
  wire           c_ready, nz_ready, b_rd_en, pe_load_en, pe_acc_en, d_valid, busy, err_oob;
  wire [CW-1:0]  b_rd_addr;
  wire [DW-1:0]  pe_A_element;
  wire [RW-1:0]  pe_B_row, pe_C_row, d_row;

  stc_row_sched #(.N(N), .DW_DATA(DW), .K(K), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset),
    .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_empty(c_empty),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_value(nz_value), .nz_col(nz_col), .nz_last(nz_last),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .pe_A_element(pe_A_element), .pe_B_row(pe_B_row), .pe_C_row(pe_C_row),
    .pe_load_en(pe_load_en), .pe_acc_en(pe_acc_en), .pe_D_row(psum),
    .d_valid(d_valid), .d_ready(d_ready), .d_row(d_row), .busy(busy), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_rd = 0, n_nzr = 0, n_hs = 0;
  int nvec = 0, nerr = 0;
  logic [RW-1:0] bmem [0:K-1];
  logic [RW-1:0] exp_row [$];
  int            exp_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b_rd_en) n_rd <= n_rd + 1;
    if (nz_ready) n_nzr <= n_nzr + 1;
    if (d_valid && d_ready) n_hs <= n_hs + 1;
  end

  // B buffer: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
    else b_rd_data <= $urandom;
  end

  // PE with one multiply stage; accumulates on every non-load cycle.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      prod[i*DW +: DW] <= 8'(pe_A_element * pe_B_row[i*DW +: DW]);
      if (pe_load_en) psum[i*DW +: DW] <= pe_C_row[i*DW +: DW];
      else psum[i*DW +: DW] <= psum[i*DW +: DW] + prod[i*DW +: DW];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops one entry at the first d_valid cycle of each row.
  initial begin
    logic [RW-1:0] hold;
    logic          in_row;
    int            last_hs;
    hold = '0; in_row = 1'b0; last_hs = 0;
    forever begin
      @(negedge clk);
      if (!reset) in_row = 1'b0;
      else begin
        if (n_hs != last_hs) begin
          in_row  = 1'b0;
          last_hs = n_hs;
        end
        if (d_valid) begin
          if (!in_row) begin
            if (exp_row.size() == 0) begin
              nvec++; nerr++;
              $display("FAIL unexpected_d_valid: got d_row %0h expected no output", d_row);
            end else begin
              chk("d_row", d_row, exp_row.pop_front());
              chk("d_valid_cycle", cyc, exp_cyc.pop_front());
            end
            hold   = d_row;
            in_row = 1'b1;
          end else chk("d_row_stable", d_row, hold);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_c_ready"}, c_ready, 1);
    chk({tag, "_nz_ready"}, nz_ready, 0);
    chk({tag, "_b_rd_en"}, b_rd_en, 0);
    chk({tag, "_b_rd_addr"}, b_rd_addr, 0);
    chk({tag, "_pe_A"}, pe_A_element, 0);
    chk({tag, "_pe_B"}, pe_B_row, 0);
    chk({tag, "_pe_C"}, pe_C_row, 0);
    chk({tag, "_load_en"}, pe_load_en, 0);
    chk({tag, "_acc_en"}, pe_acc_en, 0);
    chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_d_row"}, d_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_oob"}, err_oob, 0);
  endtask

  task automatic send_c(input logic [RW-1:0] row, input logic emp, output int t);
    int n = 0;
    c_valid = 1'b1; c_row = row; c_empty = emp;
    while (!c_ready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("c_accept", c_ready, 1);
    t = cyc;
    @(negedge clk);
    c_valid = 1'b0; c_empty = 1'b0; c_row = '0;
  endtask

  // Leaves nz_valid asserted so consecutive calls are back-to-back.
  task automatic send_nz(input logic [DW-1:0] v, input logic [CW-1:0] col, input logic last,
                         output int l);
    int n = 0;
    nz_valid = 1'b1; nz_value = v; nz_col = col; nz_last = last;
    while (!nz_ready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("nz_accept", nz_ready, 1);
    l = cyc;
    @(negedge clk);
  endtask

  initial begin
    int t, l, rd0, nzr0, n;
    for (int i = 0; i < K; i++) bmem[i] = $urandom;
    bmem[1] = {8'd16, 8'd16, 8'd16, 8'd16};
    bmem[2] = {8'd4, 8'd3, 8'd2, 8'd1};
    bmem[5] = {8'd10, 8'd10, 8'd10, 8'd10};

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      c_valid = 1'($urandom); c_row = $urandom; c_empty = 1'($urandom);
      nz_valid = 1'($urandom); nz_value = 8'($urandom); nz_col = 5'($urandom);
      nz_last = 1'($urandom); d_ready = 1'($urandom);
    end
    @(negedge clk);
    c_valid = 1'b0; c_row = '0; c_empty = 1'b0; nz_valid = 1'b0; nz_value = '0;
    nz_col = '0; nz_last = 1'b0; d_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst");

    // Basic row: 1 + 3*B[2] + 2*B[5].
    send_c({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, t);
    send_nz(8'd3, 5'd2, 1'b0, l);
    send_nz(8'd2, 5'd5, 1'b1, l);
    nz_valid = 1'b0; nz_last = 1'b0;
    exp_row.push_back({8'd33, 8'd30, 8'd27, 8'd24});
    exp_cyc.push_back(l + ML + 2);

    // Gaps and lane wrap: 16*16 + 16*16 = 512 -> 0.
    send_c('0, 1'b0, t);
    send_nz(8'd16, 5'd1, 1'b0, l);
    nz_valid = 1'b0;
    chk("issue_A", pe_A_element, 16);
    @(negedge clk);
    chk("gap_A1", pe_A_element, 0);
    @(negedge clk);
    chk("gap_A2", pe_A_element, 0);
    chk("gap_acc", pe_acc_en, 0);
    send_nz(8'd16, 5'd1, 1'b1, l);
    nz_valid = 1'b0; nz_last = 1'b0;
    exp_row.push_back('0);
    exp_cyc.push_back(l + ML + 2);

    // Empty row: C passes straight through.
    rd0 = n_rd; nzr0 = n_nzr;
    send_c({8'd7, 8'd7, 8'd7, 8'd7}, 1'b1, t);
    exp_row.push_back({8'd7, 8'd7, 8'd7, 8'd7});
    exp_cyc.push_back(t + ML + 3);
    repeat (6) @(negedge clk);
    chk("empty_no_rd", n_rd, rd0);
    chk("empty_no_nzr", n_nzr, nzr0);

    // Out-of-range column, then backpressure on D.
    chk("oob_before", err_oob, 0);
    rd0 = n_rd;
    send_c('0, 1'b0, t);
    send_nz(8'd5, 5'd2, 1'b0, l);
    send_nz(8'd9, 5'd31, 1'b1, l);
    nz_valid = 1'b0; nz_last = 1'b0; d_ready = 1'b0;
    chk("oob_set", err_oob, 1);
    chk("oob_no_rd", n_rd, rd0 + 1);
    exp_row.push_back({8'd20, 8'd15, 8'd10, 8'd5});
    exp_cyc.push_back(l + ML + 2);
    n = 0;
    while (!d_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("bp_d_valid", d_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", d_valid, 1);
      chk("bp_no_c_ready", c_ready, 0);
    end
    chk("oob_sticky", err_oob, 1);
    d_ready = 1'b1;

    // Reset in the middle of ISSUE abandons the row.
    send_c({8'd9, 8'd9, 8'd9, 8'd9}, 1'b0, t);
    send_nz(8'd1, 5'd5, 1'b0, l);
    nz_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_idle("midrst");
    @(negedge clk);
    reset = 1'b1;
    send_c('0, 1'b0, t);
    send_nz(8'd1, 5'd2, 1'b1, l);
    nz_valid = 1'b0; nz_last = 1'b0;
    exp_row.push_back({8'd4, 8'd3, 8'd2, 8'd1});
    exp_cyc.push_back(l + ML + 2);

    n = 0;
    while (exp_row.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("scoreboard_drained", exp_row.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_idle", c_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
